// File: rtl/rop_dcr_unit.sv
// ROP device-configuration-register responder: host writes land in a shadow copy,
// which a commit handshake transfers atomically into the active copy while the pipe is idle.
package rop_types;
  // Declared MSB-first so the packed bits line up with the 32-bit register layout.
  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] ref_val;
    logic [2:0] fail;
    logic [2:0] zfail;
    logic [2:0] zpass;
    logic [2:0] func;
  } stencil_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } blend_const_t;

  typedef struct packed {
    logic [31:0]  cbuf_addr;
    logic [31:0]  cbuf_pitch;
    logic [31:0]  cbuf_mask;
    logic [31:0]  zbuf_addr;
    logic [31:0]  zbuf_pitch;
    logic [2:0]   depth_func;
    logic         depth_writemask;
    stencil_t     stencil_front;
    stencil_t     stencil_back;
    logic [7:0]   stencil_writemask;
    logic [2:0]   blend_mode_rgb;
    logic [2:0]   blend_mode_a;
    logic [3:0]   blend_src_rgb;
    logic [3:0]   blend_src_a;
    logic [3:0]   blend_dst_rgb;
    logic [3:0]   blend_dst_a;
    blend_const_t blend_const;
    logic [3:0]   logic_op;
  } rop_dcrs_t;

  function automatic rop_dcrs_t rop_dcrs_reset();
    rop_dcrs_t d;
    d = '0;
    d.cbuf_mask          = 32'hFFFF_FFFF;
    d.depth_func         = 3'd7;
    d.stencil_front.func = 3'd7;
    d.stencil_back.func  = 3'd7;
    d.stencil_front.mask = 8'hFF;
    d.stencil_back.mask  = 8'hFF;
    d.stencil_writemask  = 8'hFF;
    d.blend_src_rgb      = 4'd1;
    d.blend_src_a        = 4'd1;
    d.logic_op           = 4'd3;
    return d;
  endfunction
endpackage

module rop_dcr_unit
  import rop_types::*;
#(
  parameter int                     DCR_ADDR_BITS = 12,
  parameter logic [DCR_ADDR_BITS-1:0] DCR_BASE    = 12'h100,
  parameter int                     NUM_REGS      = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dcr_wr_valid,
  output logic                     dcr_wr_ready,
  input  logic [DCR_ADDR_BITS-1:0] dcr_wr_addr,
  input  logic [31:0]              dcr_wr_data,
  input  logic                     dcr_rd_valid,
  input  logic [DCR_ADDR_BITS-1:0] dcr_rd_addr,
  input  logic                     dcr_rd_sel,
  output logic                     dcr_rsp_valid,
  output logic [31:0]              dcr_rsp_data,
  input  logic                     commit_valid,
  output logic                     commit_ready,
  output logic                     commit_done,
  input  logic                     pipe_idle,
  output rop_dcrs_t                rop_dcrs
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t    state_reg, state_next;
  rop_dcrs_t shadow_reg, active_reg;
  logic      do_copy;

  logic [DCR_ADDR_BITS-1:0] wr_off, rd_off;
  logic                     wr_hit, rd_hit;

  // Addresses below the base wrap to large offsets, but the explicit >= keeps that obvious.
  assign wr_off = dcr_wr_addr - DCR_BASE;
  assign rd_off = dcr_rd_addr - DCR_BASE;
  assign wr_hit = (dcr_wr_addr >= DCR_BASE) && (wr_off < DCR_ADDR_BITS'(NUM_REGS));
  assign rd_hit = (dcr_rd_addr >= DCR_BASE) && (rd_off < DCR_ADDR_BITS'(NUM_REGS));

  function automatic logic [31:0] get_word(input rop_dcrs_t d, input logic [3:0] off);
    logic [31:0] w;
    w = '0;
    case (off)
      4'd0:  w = d.cbuf_addr;
      4'd1:  w = d.cbuf_pitch;
      4'd2:  w = d.cbuf_mask;
      4'd3:  w = d.zbuf_addr;
      4'd4:  w = d.zbuf_pitch;
      4'd5:  w[3:0]  = {d.depth_writemask, d.depth_func};
      4'd6:  w[27:0] = d.stencil_front;
      4'd7:  w[27:0] = d.stencil_back;
      4'd8:  w[7:0]  = d.stencil_writemask;
      4'd9:  w[5:0]  = {d.blend_mode_a, d.blend_mode_rgb};
      4'd10: w[15:0] = {d.blend_dst_a, d.blend_dst_rgb, d.blend_src_a, d.blend_src_rgb};
      4'd11: w = d.blend_const;
      4'd12: w[3:0]  = d.logic_op;
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic rop_dcrs_t set_word(input rop_dcrs_t d, input logic [3:0] off,
                                         input logic [31:0] w);
    rop_dcrs_t r;
    r = d;
    case (off)
      4'd0:  r.cbuf_addr  = w;
      4'd1:  r.cbuf_pitch = w;
      4'd2:  r.cbuf_mask  = w;
      4'd3:  r.zbuf_addr  = w;
      4'd4:  r.zbuf_pitch = w;
      4'd5:  {r.depth_writemask, r.depth_func} = w[3:0];
      4'd6:  r.stencil_front = w[27:0];
      4'd7:  r.stencil_back  = w[27:0];
      4'd8:  r.stencil_writemask = w[7:0];
      4'd9:  {r.blend_mode_a, r.blend_mode_rgb} = w[5:0];
      4'd10: {r.blend_dst_a, r.blend_dst_rgb, r.blend_src_a, r.blend_src_rgb} = w[15:0];
      4'd11: r.blend_const = w;
      4'd12: r.logic_op = w[3:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_next   = state_reg;
    dcr_wr_ready = 1'b0;
    commit_ready = 1'b0;
    do_copy      = 1'b0;
    case (state_reg)
      IDLE: begin
        dcr_wr_ready = 1'b1;
        commit_ready = 1'b1;
        if (commit_valid) state_next = PENDING;
      end
      PENDING: begin
        // Writes are held off here so the snapshot cannot change under the commit.
        if (pipe_idle) begin
          do_copy    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      shadow_reg    <= rop_dcrs_reset();
      active_reg    <= rop_dcrs_reset();
      commit_done   <= 1'b0;
      dcr_rsp_valid <= 1'b0;
      dcr_rsp_data  <= '0;
    end else begin
      state_reg <= state_next;
      if (dcr_wr_valid && dcr_wr_ready && wr_hit)
        shadow_reg <= set_word(shadow_reg, wr_off[3:0], dcr_wr_data);
      if (do_copy)
        active_reg <= shadow_reg;
      commit_done   <= do_copy;
      dcr_rsp_valid <= dcr_rd_valid;
      dcr_rsp_data  <= (dcr_rd_valid && rd_hit)
                       ? get_word(dcr_rd_sel ? active_reg : shadow_reg, rd_off[3:0]) : '0;
    end
  end

  assign rop_dcrs = active_reg;

endmodule

// File: tb/tb_rop_dcr_unit.sv
// Bench for rop_dcr_unit: word-array model of the register map checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_rop_dcr_unit;
  import rop_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, rd_valid, rd_sel, commit_valid, pipe_idle;
  logic [11:0] wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic        wr_ready, rsp_valid, commit_ready, commit_done;
  logic [31:0] rsp_data;
  rop_dcrs_t   dcrs;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  rop_dcr_unit dut (
    .clk(clk), .reset(rst),
    .dcr_wr_valid(wr_valid), .dcr_wr_ready(wr_ready), .dcr_wr_addr(wr_addr), .dcr_wr_data(wr_data),
    .dcr_rd_valid(rd_valid), .dcr_rd_addr(rd_addr), .dcr_rd_sel(rd_sel),
    .dcr_rsp_valid(rsp_valid), .dcr_rsp_data(rsp_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_done(commit_done),
    .pipe_idle(pipe_idle), .rop_dcrs(dcrs)
  );

  // ---------------- model: 13 register words, shadow and active ----------------
  logic [31:0] m_sh [13];
  logic [31:0] m_act[13];
  logic        m_pend, m_done, m_rv;
  logic [31:0] m_rd;

  function automatic logic [31:0] rst_word(input int i);
    case (i)
      2:       return 32'hFFFF_FFFF;
      5:       return 32'h0000_0007;
      6, 7:    return 32'h0FF0_0007;
      8:       return 32'h0000_00FF;
      10:      return 32'h0000_0011;
      12:      return 32'h0000_0003;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mask_word(input int i);
    case (i)
      5, 12:   return 32'h0000_000F;
      6, 7:    return 32'h0FFF_FFFF;
      8:       return 32'h0000_00FF;
      9:       return 32'h0000_003F;
      10:      return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic int offset_of(input logic [11:0] addr);
    int off;
    off = int'(addr) - 256;
    return (off >= 0 && off < 13) ? off : -1;
  endfunction

  function automatic logic [31:0] m_read(input logic sel, input logic [11:0] addr);
    int off;
    off = offset_of(addr);
    if (off < 0) return 32'h0;
    return sel ? m_act[off] : m_sh[off];
  endfunction

  function automatic rop_dcrs_t exp_struct();
    rop_dcrs_t e;
    e.cbuf_addr  = m_act[0];
    e.cbuf_pitch = m_act[1];
    e.cbuf_mask  = m_act[2];
    e.zbuf_addr  = m_act[3];
    e.zbuf_pitch = m_act[4];
    e.depth_func = m_act[5][2:0];
    e.depth_writemask = m_act[5][3];
    e.stencil_front.func    = m_act[6][2:0];
    e.stencil_front.zpass   = m_act[6][5:3];
    e.stencil_front.zfail   = m_act[6][8:6];
    e.stencil_front.fail    = m_act[6][11:9];
    e.stencil_front.ref_val = m_act[6][19:12];
    e.stencil_front.mask    = m_act[6][27:20];
    e.stencil_back.func     = m_act[7][2:0];
    e.stencil_back.zpass    = m_act[7][5:3];
    e.stencil_back.zfail    = m_act[7][8:6];
    e.stencil_back.fail     = m_act[7][11:9];
    e.stencil_back.ref_val  = m_act[7][19:12];
    e.stencil_back.mask     = m_act[7][27:20];
    e.stencil_writemask = m_act[8][7:0];
    e.blend_mode_rgb = m_act[9][2:0];
    e.blend_mode_a   = m_act[9][5:3];
    e.blend_src_rgb  = m_act[10][3:0];
    e.blend_src_a    = m_act[10][7:4];
    e.blend_dst_rgb  = m_act[10][11:8];
    e.blend_dst_a    = m_act[10][15:12];
    e.blend_const.a  = m_act[11][31:24];
    e.blend_const.r  = m_act[11][23:16];
    e.blend_const.g  = m_act[11][15:8];
    e.blend_const.b  = m_act[11][7:0];
    e.logic_op       = m_act[12][3:0];
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 13; i++) begin
        m_sh[i]  <= rst_word(i);
        m_act[i] <= rst_word(i);
      end
      m_pend <= 1'b0;
      m_done <= 1'b0;
      m_rv   <= 1'b0;
      m_rd   <= 32'h0;
    end else begin
      m_rv   <= rd_valid;
      m_rd   <= rd_valid ? m_read(rd_sel, rd_addr) : 32'h0;
      m_done <= m_pend && pipe_idle;
      if (m_pend) begin
        if (pipe_idle) begin
          for (int i = 0; i < 13; i++) m_act[i] <= m_sh[i];
          m_pend <= 1'b0;
        end
      end else begin
        if (wr_valid && offset_of(wr_addr) >= 0)
          m_sh[offset_of(wr_addr)] <= wr_data & mask_word(offset_of(wr_addr));
        if (commit_valid) m_pend <= 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
      chk("commit_ready", 32'(commit_ready), 32'(!m_pend));
      chk("commit_done", 32'(commit_done), 32'(m_done));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("rsp_data", rsp_data, m_rd);
      n_checks++;
      if (dcrs !== exp_struct()) begin
        n_fail++;
        $display("FAIL rop_dcrs: got %h, expected %h", dcrs, exp_struct());
      end
    end
  end

  always @(negedge clk) if (commit_done) done_cnt++;

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_valid = 1'b0;
    $display("write %h <= %h", a, d);
  endtask

  task automatic rd(input logic [11:0] a, input logic s, output logic [31:0] d);
    rd_valid = 1'b1; rd_addr = a; rd_sel = s;
    @(negedge clk);
    d = rsp_data;
    #1 rd_valid = 1'b0;
    $display("read  %h sel=%0d -> %h", a, s, d);
  endtask

  task automatic commit_pulse();
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    $display("commit request, pipe_idle=%0d", pipe_idle);
  endtask

  logic [31:0] d;
  int n0;

  initial begin
    wr_valid = 0; rd_valid = 0; rd_sel = 0; commit_valid = 0; pipe_idle = 1;
    wr_addr = 0; rd_addr = 0; wr_data = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();

    // reset values
    chk("rst cbuf_mask", dcrs.cbuf_mask, 32'hFFFF_FFFF);
    chk("rst depth_func", 32'(dcrs.depth_func), 32'd7);
    chk("rst stencil_writemask", 32'(dcrs.stencil_writemask), 32'hFF);
    chk("rst blend_src_rgb", 32'(dcrs.blend_src_rgb), 32'd1);
    chk("rst logic_op", 32'(dcrs.logic_op), 32'd3);
    chk("rst cbuf_addr", dcrs.cbuf_addr, 32'h0);
    chk("rst commit_ready", 32'(commit_ready), 32'd1);

    // shadow isolation
    wr(12'h100, 32'h8000_0000);
    rd(12'h100, 1'b0, d); chk("shadow read", d, 32'h8000_0000);
    rd(12'h100, 1'b1, d); chk("active read", d, 32'h0);
    chk("active cbuf_addr", dcrs.cbuf_addr, 32'h0);

    // commit with idle pipe
    wr(12'h106, 32'h0FF7_A1C9);
    wr(12'h10B, 32'h80FF_4020);
    n0 = done_cnt;
    commit_pulse();
    step(); step();
    chk("sf func", 32'(dcrs.stencil_front.func), 32'd1);
    chk("sf zpass", 32'(dcrs.stencil_front.zpass), 32'd1);
    chk("sf zfail", 32'(dcrs.stencil_front.zfail), 32'd7);
    chk("sf fail", 32'(dcrs.stencil_front.fail), 32'd0);
    chk("sf ref", 32'(dcrs.stencil_front.ref_val), 32'h7A);
    chk("sf mask", 32'(dcrs.stencil_front.mask), 32'hFF);
    chk("blend_const", dcrs.blend_const, 32'h80FF_4020);
    chk("done pulses idle", 32'(done_cnt - n0), 32'd1);

    // busy pipe: commit waits, writes are refused meanwhile
    wr(12'h100, 32'h1234_5678);
    pipe_idle = 1'b0;
    commit_pulse();
    n0 = done_cnt;
    wr_valid = 1'b1; wr_addr = 12'h101; wr_data = 32'hCAFE_0001;
    repeat (10) step();
    wr_valid = 1'b0;
    chk("busy wr_ready", 32'(wr_ready), 32'd0);
    chk("busy commit_ready", 32'(commit_ready), 32'd0);
    chk("busy cbuf_addr", dcrs.cbuf_addr, 32'h8000_0000);
    chk("busy no done", 32'(done_cnt - n0), 32'd0);
    pipe_idle = 1'b1;
    step(); step();
    chk("after busy cbuf_addr", dcrs.cbuf_addr, 32'h1234_5678);
    chk("done pulses busy", 32'(done_cnt - n0), 32'd1);
    rd(12'h101, 1'b0, d); chk("refused write", d, 32'h0);

    // address edges and masked fields
    wr(12'h10D, 32'hDEAD_BEEF);
    wr(12'h0FF, 32'h0000_0001);
    rd(12'h10D, 1'b0, d); chk("read 0x10D", d, 32'h0);
    rd(12'h0FF, 1'b0, d); chk("read 0x0FF", d, 32'h0);
    rd(12'h10C, 1'b0, d); chk("read 0x10C", d, 32'h3);
    wr(12'h105, 32'hFFFF_FFFF);
    rd(12'h105, 1'b0, d); chk("off5 mask", d, 32'h0000_000F);

    // read and write of the same offset in one cycle returns the old value
    wr_valid = 1'b1; wr_addr = 12'h108; wr_data = 32'h55;
    rd_valid = 1'b1; rd_addr = 12'h108; rd_sel = 1'b0;
    @(negedge clk);
    d = rsp_data;
    #1 wr_valid = 1'b0; rd_valid = 1'b0;
    $display("write+read 108 -> %h", d);
    chk("rd-wr same cycle", d, 32'hFF);
    rd(12'h108, 1'b0, d); chk("rd after wr", d, 32'h55);

    // commit held high: back-to-back requests
    n0 = done_cnt;
    commit_valid = 1'b1;
    repeat (6) step();
    commit_valid = 1'b0;
    step(); step();
    $display("held commit, done pulses %0d", done_cnt - n0);
    chk("held commit pulses", 32'(done_cnt - n0), 32'd3);

    // reset during PENDING
    pipe_idle = 1'b0;
    wr(12'h10C, 32'h5);
    commit_pulse();
    step(); step();
    n0 = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    pipe_idle = 1'b1;
    step(); step();
    $display("reset mid-commit done");
    chk("rst-pend no done", 32'(done_cnt - n0), 32'd0);
    chk("rst-pend logic_op", 32'(dcrs.logic_op), 32'd3);
    chk("rst-pend cbuf_mask", dcrs.cbuf_mask, 32'hFFFF_FFFF);
    chk("rst-pend cbuf_addr", dcrs.cbuf_addr, 32'h0);
    chk("rst-pend sf mask", 32'(dcrs.stencil_front.mask), 32'hFF);
    rd(12'h10C, 1'b0, d); chk("rst-pend shadow", d, 32'h3);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected end of stimulus");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rop_dcr_unit.md
Name: rop_dcr_unit

Overview:
Responder for ROP device-configuration-register (DCR) traffic. It decodes host DCR writes into a shadow copy of the rop_types::rop_dcrs_t packed struct. On a commit handshake, and only while the ROP pipeline is idle, it atomically transfers the shadow copy into the active copy that drives the ROP pipeline. It also provides registered readback of either copy.

Parameters:
DCR_ADDR_BITS, 12, width of DCR address bus
DCR_BASE, 12'h100, DCR address of ROP register offset 0
NUM_REGS, 13, number of mapped 32-bit ROP DCR words (offsets 0..12)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
dcr_wr_valid  in  1  write request
dcr_wr_ready  out  1  write accepted when valid&ready
dcr_wr_addr  in  DCR_ADDR_BITS  write address
dcr_wr_data  in  32  write data
dcr_rd_valid  in  1  read request (always accepted)
dcr_rd_addr  in  DCR_ADDR_BITS  read address
dcr_rd_sel  in  1  0 = read shadow, 1 = read active
dcr_rsp_valid  out  1  read response strobe
dcr_rsp_data  out  32  read response data
commit_valid  in  1  request shadow-to-active transfer
commit_ready  out  1  commit request accepted
commit_done  out  1  one-cycle pulse after active copy updated
pipe_idle  in  1  ROP pipeline has no fragments in flight
rop_dcrs  out  $bits(rop_dcrs_t)  active configuration struct

Behaviour:
- Offset map (off = addr - DCR_BASE). Unlisted bits are write-ignored and read as 0.
  - 0 cbuf_addr; 1 cbuf_pitch; 2 cbuf_mask; 3 zbuf_addr; 4 zbuf_pitch
  - 5 depth_func[2:0], depth_writemask[3]
  - 6 stencil_front: func[2:0], zpass[5:3], zfail[8:6], fail[11:9], ref[19:12], mask[27:20]
  - 7 stencil_back: same layout as offset 6
  - 8 stencil_writemask[7:0]
  - 9 blend_mode_rgb[2:0], blend_mode_a[5:3]
  - 10 blend_src_rgb[3:0], src_a[7:4], dst_rgb[11:8], dst_a[15:12]
  - 11 blend_const {a[31:24], r[23:16], g[15:8], b[7:0]}
  - 12 logic_op[3:0]
- Field widths: depth/stencil func 3, stencil op 3, stencil 8, blend mode 3, blend func 4, logic op 4.
- Reset values, applied to both shadow and active copies:
  - all fields 0, except cbuf_mask = 32'hFFFFFFFF
  - depth_func and both stencil funcs = ALWAYS (3'd7)
  - stencil front/back mask and stencil_writemask = 8'hFF
  - blend_src_rgb and blend_src_a = ONE (4'd1)
  - logic_op = COPY (4'd3)
- Output reset values: dcr_wr_ready=1, dcr_rsp_valid=0, dcr_rsp_data=0, commit_ready=1, commit_done=0.
- Writes: an accepted write at edge N updates the shadow copy at edge N. Out-of-range or unmapped offsets are accepted and dropped. Writes never touch the active copy.
- Reads: response is registered, 1-cycle latency: request at edge N gives dcr_rsp_valid=1 with data after edge N. Unmapped offsets return 0. A read and a write to the same offset in the same cycle return the pre-write value.
- Commit FSM: IDLE, PENDING.
  - IDLE: commit_ready=1, dcr_wr_ready=1. commit_valid moves to PENDING.
  - PENDING: commit_ready=0, dcr_wr_ready=0 so the shadow is frozen. When pipe_idle=1, active<=shadow at that edge, commit_done=1 for the following cycle, and the FSM returns to IDLE.
- Minimum commit latency: request edge N, copy at edge N+1, commit_done high in cycle N+1..N+2. If pipe_idle=0, the FSM waits in PENDING indefinitely.
- Write and commit_valid in the same IDLE cycle: the write lands and is included in the committed snapshot.
- commit_valid held high after completion is a new request. A back-to-back commit gets IDLE for one cycle, then PENDING.
- rop_dcrs changes only at the copy edge; the update is glitch-free and all fields change together.
- Reset asserted mid-PENDING: FSM returns to IDLE, both copies take reset values, no commit_done.

Test Plan:
- Reset check: release reset → rop_dcrs.cbuf_mask=FFFFFFFF, depth_func=7, stencil_writemask=FF, blend_src_rgb=1, logic_op=3, other fields 0; commit_ready=1.
- Shadow isolation: write 0x100←0x8000_0000, then read with sel=0 → 0x80000000; read with sel=1 and check rop_dcrs.cbuf_addr → both still 0.
- Commit with idle pipe:
  - Writes: offset 6←0x0FF7_A1C9, offset 11←0x80FF_4020.
  - Commit with pipe_idle=1 → one cycle later stencil_front_func=1, zpass=1, zfail=7, fail=0, ref=0x7A, mask=0xFF; blend_const a=0x80, r=0xFF, g=0x40, b=0x20; commit_done pulses once.
- Busy pipe: commit while pipe_idle=0 for 10 cycles → dcr_wr_ready=0, commit_ready=0, rop_dcrs unchanged. Raise pipe_idle → copy next edge, commit_done pulse.
- Edge addresses:
  - Write 0x10D←0xDEADBEEF and 0x0FF←0x1 → no state change; both reads return 0.
  - Write offset 5←0xFFFFFFFF → readback 0x0000000F.
- Reset mid-commit: assert reset in PENDING → after release all reset values present, commit_done never asserted.
